lii_tx_arb: RTL and testbench

- Transmit-side counterpart of the per-kernel LII unpack/pack wrappers.
- Takes two logical HLS kernel output streams and zero-pads each to PW bits. Tags each beat with an 8-bit src/dst route, round-robin arbitrates between them, and drives one LII physical output channel through a 2-entry registered FIFO.
- Sits between the kernel stream ports and the LII phy out channel, where several kernel streams share one physical channel.

---
 rtl/lii_tx_arb.sv | 154 +++++++++++++++
 tb/tb_lii_tx_arb.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lii_tx_arb.sv
`timescale 1ns/1ps
// lii_tx_arb
// Merges two HLS kernel output streams onto one LII physical output channel.
// Each accepted beat is zero-padded to PW bits and tagged with a route
// (src = SRC_ID, dst = DST0/DST1). Beats are queued in a 2-entry registered
// FIFO, and the phy outputs come only from the FIFO head registers.
//
// Ports
//   aclk, arst           : clock; synchronous active-high reset
//   s0_* / s1_*          : logical AXI-Stream inputs (DW0 / DW1 bits)
//   lii_out_p0_*         : physical output channel (PW data, 8-bit src/dst)
//   beat_cnt0/1          : beats of stream 0/1 that completed a phy handshake
module lii_tx_arb #(
    parameter int          PW     = 128,
    parameter int          DW0    = 56,
    parameter int          DW1    = 72,
    parameter logic [7:0]  SRC_ID = 8'h00,
    parameter logic [7:0]  DST0   = 8'h01,
    parameter logic [7:0]  DST1   = 8'h02
) (
    input  logic            aclk,
    input  logic            arst,
    input  logic [DW0-1:0]  s0_tdata,
    input  logic            s0_tvalid,
    output logic            s0_tready,
    input  logic [DW1-1:0]  s1_tdata,
    input  logic            s1_tvalid,
    output logic            s1_tready,
    output logic [PW-1:0]   lii_out_p0_tdata,
    output logic            lii_out_p0_tvalid,
    input  logic            lii_out_p0_tready,
    output logic [7:0]      lii_out_p0_src,
    output logic [7:0]      lii_out_p0_dst,
    output logic [31:0]     beat_cnt0,
    output logic [31:0]     beat_cnt1
);

    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          rr_q, rr_d;
    logic [31:0]   cnt0_q, cnt0_d;
    logic [31:0]   cnt1_q, cnt1_d;

    logic [PW-1:0] data_q [2];
    logic [7:0]    dst_q  [2];
    // Hidden source index per entry, so counters stay correct even if DST0 == DST1.
    logic [1:0]    sidx_q;

    logic          pop;
    logic          push;
    logic          space;
    logic          grant;
    logic [PW-1:0] push_data;
    logic [7:0]    push_dst;

    always_comb begin
        pop       = 1'b0;
        space     = 1'b0;
        grant     = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_dst  = DST0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rr_d      = rr_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;

        pop   = (count_q != 2'd0) && lii_out_p0_tready;
        // A full FIFO still has room when its head leaves in the same cycle.
        space = (count_q < 2'd2) || pop;

        if (s0_tvalid && s1_tvalid) begin
            grant = rr_q;
        end else if (s1_tvalid) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end

        s0_tready = space && !grant && !arst;
        s1_tready = space &&  grant && !arst;

        if (s0_tvalid && s0_tready) begin
            push               = 1'b1;
            push_data[DW0-1:0] = s0_tdata;
            push_dst           = DST0;
        end else if (s1_tvalid && s1_tready) begin
            push               = 1'b1;
            push_data[DW1-1:0] = s1_tdata;
            push_dst           = DST1;
        end

        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
            rr_d     = ~grant;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (sidx_q[rd_ptr_q]) begin
                cnt1_d = cnt1_q + 32'd1;
            end else begin
                cnt0_d = cnt0_q + 32'd1;
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rr_q     <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            sidx_q   <= '0;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                dst_q[i]  <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q     <= rr_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            if (push) begin
                data_q[wr_ptr_q] <= push_data;
                dst_q[wr_ptr_q]  <= push_dst;
                sidx_q[wr_ptr_q] <= grant;
            end
        end
    end

    // Head entry is gated by valid so an empty FIFO presents all-zero outputs.
    assign lii_out_p0_tvalid = (count_q != 2'd0);
    assign lii_out_p0_tdata  = lii_out_p0_tvalid ? data_q[rd_ptr_q] : '0;
    assign lii_out_p0_dst    = lii_out_p0_tvalid ? dst_q[rd_ptr_q]  : 8'h00;
    assign lii_out_p0_src    = lii_out_p0_tvalid ? SRC_ID           : 8'h00;
    assign beat_cnt0         = cnt0_q;
    assign beat_cnt1         = cnt1_q;

endmodule

// File: tb/tb_lii_tx_arb.sv
`timescale 1ns/1ps
module tb_lii_tx_arb;

    logic          aclk;
    logic          arst;
    logic [55:0]   s0_tdata;
    logic          s0_tvalid;
    logic          s0_tready;
    logic [71:0]   s1_tdata;
    logic          s1_tvalid;
    logic          s1_tready;
    logic [127:0]  lii_out_p0_tdata;
    logic          lii_out_p0_tvalid;
    logic          lii_out_p0_tready;
    logic [7:0]    lii_out_p0_src;
    logic [7:0]    lii_out_p0_dst;
    logic [31:0]   beat_cnt0;
    logic [31:0]   beat_cnt1;

    typedef struct packed {
        logic [7:0]   dst;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    lii_tx_arb dut (
        .aclk              (aclk),
        .arst              (arst),
        .s0_tdata          (s0_tdata),
        .s0_tvalid         (s0_tvalid),
        .s0_tready         (s0_tready),
        .s1_tdata          (s1_tdata),
        .s1_tvalid         (s1_tvalid),
        .s1_tready         (s1_tready),
        .lii_out_p0_tdata  (lii_out_p0_tdata),
        .lii_out_p0_tvalid (lii_out_p0_tvalid),
        .lii_out_p0_tready (lii_out_p0_tready),
        .lii_out_p0_src    (lii_out_p0_src),
        .lii_out_p0_dst    (lii_out_p0_dst),
        .beat_cnt0         (beat_cnt0),
        .beat_cnt1         (beat_cnt1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        arst              = 1'b1;
        s0_tvalid         = 1'b0;
        s1_tvalid         = 1'b0;
        lii_out_p0_tready = 1'b0;
        tick();
        tick();
        arst = 1'b0;
    endtask

    task automatic send_s0(input logic [55:0] d);
        bit acc = 0;
        s0_tdata  = d;
        s0_tvalid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge aclk);
            if (s0_tready) acc = 1;
            tick();
        end
        s0_tvalid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_s0_timeout: data=%h not accepted, required accept within 20 cycles", d);
        end
    endtask

    task automatic send_s1(input logic [71:0] d);
        bit acc = 0;
        s1_tdata  = d;
        s1_tvalid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge aclk);
            if (s1_tready) acc = 1;
            tick();
        end
        s1_tvalid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_s1_timeout: data=%h not accepted, required accept within 20 cycles", d);
        end
    endtask

    task automatic test_reset();
        arst              = 1'b1;
        s0_tvalid         = 1'b1;
        s1_tvalid         = 1'b1;
        lii_out_p0_tready = 1'b1;
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if ({s0_tready, s1_tready, lii_out_p0_tvalid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_valid: got s0r=%b s1r=%b tv=%b, required 0 0 0",
                     s0_tready, s1_tready, lii_out_p0_tvalid);
        end
        checks++;
        if (lii_out_p0_tdata !== 128'h0 || lii_out_p0_src !== 8'h00 || lii_out_p0_dst !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got tdata=%h src=%h dst=%h, required all 0",
                     lii_out_p0_tdata, lii_out_p0_src, lii_out_p0_dst);
        end
        checks++;
        if (beat_cnt0 !== 32'd0 || beat_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d, required 0 0", beat_cnt0, beat_cnt1);
        end
        tick();
        arst      = 1'b0;
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        lii_out_p0_tready = 1'b1;
        send_s0(56'hABCDEF);
        @(negedge aclk);
        checks++;
        if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata !== 128'h0000_0000_0000_0000_0000_0000_00AB_CDEF ||
            lii_out_p0_src !== 8'h00 || lii_out_p0_dst !== 8'h01) begin
            errors++;
            $display("FAIL single_beat: got tv=%b tdata=%h src=%h dst=%h, required 1 %h 00 01",
                     lii_out_p0_tvalid, lii_out_p0_tdata, lii_out_p0_src, lii_out_p0_dst, 128'hABCDEF);
        end
        tick();
        @(negedge aclk);
        checks++;
        if (lii_out_p0_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: got tv=%b, required 0", lii_out_p0_tvalid);
        end
        checks++;
        if (beat_cnt0 !== 32'd1 || beat_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL single_counters: got %0d %0d, required 1 0", beat_cnt0, beat_cnt1);
        end
        tick();
    endtask

    task automatic test_alternate();
        int  n_acc = 0;
        bit  a0, a1;
        do_reset();
        lii_out_p0_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s0_tdata  = 56'(i + 100);
            s1_tdata  = 72'(i + 200);
            s0_tvalid = 1'b1;
            s1_tvalid = 1'b1;
            @(negedge aclk);
            a0 = s0_tvalid && s0_tready;
            a1 = s1_tvalid && s1_tready;
            checks++;
            if (a0 !== ((i % 2) == 0) || a1 !== ((i % 2) == 1)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got s0_acc=%b s1_acc=%b, required %b %b",
                         i, a0, a1, (i % 2) == 0, (i % 2) == 1);
            end
            n_acc += int'(a0) + int'(a1);
            tick();
        end
        s0_tvalid = 1'b0;
        s1_tvalid = 1'b0;
        checks++;
        if (n_acc != 8) begin
            errors++;
            $display("FAIL alt_throughput: got %0d beats in 8 cycles, required 8", n_acc);
        end
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if (beat_cnt0 !== 32'd4 || beat_cnt1 !== 32'd4 || sb.size() != 0) begin
            errors++;
            $display("FAIL alt_counters: got cnt0=%0d cnt1=%0d pending=%0d, required 4 4 0",
                     beat_cnt0, beat_cnt1, sb.size());
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit acc = 0;
        do_reset();
        lii_out_p0_tready = 1'b0;
        s1_tvalid         = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            s1_tdata = 72'(k);
            @(negedge aclk);
            checks++;
            if (s1_tready !== (k < 3)) begin
                errors++;
                $display("FAIL bp_accept[%0d]: got s1_tready=%b, required %b", k, s1_tready, k < 3);
            end
            if (k < 3) tick();
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            checks++;
            if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata !== 128'd1 ||
                lii_out_p0_dst !== 8'h02 || s1_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got tv=%b tdata=%h dst=%h s1r=%b, required 1 1 02 0",
                         i, lii_out_p0_tvalid, lii_out_p0_tdata, lii_out_p0_dst, s1_tready);
            end
            tick();
        end
        lii_out_p0_tready = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge aclk);
            if (s1_tready) acc = 1;
            tick();
        end
        s1_tvalid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL bp_third_timeout: beat 3 not accepted, required accept after release");
        end
        tick();
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if (beat_cnt1 !== 32'd3 || beat_cnt0 !== 32'd0 || sb.size() != 0 || lii_out_p0_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got cnt1=%0d cnt0=%0d pending=%0d tv=%b, required 3 0 0 0",
                     beat_cnt1, beat_cnt0, sb.size(), lii_out_p0_tvalid);
        end
        tick();
    endtask

    task automatic test_full_pushpop();
        do_reset();
        lii_out_p0_tready = 1'b0;
        send_s0(56'hA1);
        send_s0(56'hB2);
        s0_tdata          = 56'hC3;
        s0_tvalid         = 1'b1;
        lii_out_p0_tready = 1'b1;
        @(negedge aclk);
        checks++;
        if (s0_tready !== 1'b1 || lii_out_p0_tdata !== 128'hA1) begin
            errors++;
            $display("FAIL full_pushpop_accept: got s0r=%b head=%h, required 1 a1", s0_tready, lii_out_p0_tdata);
        end
        tick();
        lii_out_p0_tready = 1'b0;
        s0_tdata          = 56'hD4;
        @(negedge aclk);
        checks++;
        if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata !== 128'hB2 || s0_tready !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop_count: got tv=%b head=%h s0r=%b, required 1 b2 0 (still full)",
                     lii_out_p0_tvalid, lii_out_p0_tdata, s0_tready);
        end
        tick();
        s0_tvalid         = 1'b0;
        lii_out_p0_tready = 1'b1;
        tick();
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if (beat_cnt0 !== 32'd3 || sb.size() != 0 || lii_out_p0_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop_drain: got cnt0=%0d pending=%0d tv=%b, required 3 0 0",
                     beat_cnt0, sb.size(), lii_out_p0_tvalid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        lii_out_p0_tready = 1'b1;
        send_s0(56'h01);
        tick();
        lii_out_p0_tready = 1'b0;
        send_s0(56'h11);
        send_s1(72'h22);
        arst      = 1'b1;
        s0_tvalid = 1'b1;
        s1_tvalid = 1'b1;
        @(negedge aclk);
        checks++;
        if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: got s0r=%b s1r=%b, required 0 0", s0_tready, s1_tready);
        end
        tick();
        @(negedge aclk);
        checks++;
        if (lii_out_p0_tvalid !== 1'b0 || beat_cnt0 !== 32'd0 || beat_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL midrst_cleared: got tv=%b cnt0=%0d cnt1=%0d, required 0 0 0",
                     lii_out_p0_tvalid, beat_cnt0, beat_cnt1);
        end
        tick();
        arst              = 1'b0;
        s0_tvalid         = 1'b0;
        s1_tvalid         = 1'b0;
        lii_out_p0_tready = 1'b1;
        send_s1(72'h55);
        @(negedge aclk);
        checks++;
        if (lii_out_p0_tvalid !== 1'b1 || lii_out_p0_tdata !== 128'h55 || lii_out_p0_dst !== 8'h02) begin
            errors++;
            $display("FAIL midrst_first_beat: got tv=%b tdata=%h dst=%h, required 1 55 02",
                     lii_out_p0_tvalid, lii_out_p0_tdata, lii_out_p0_dst);
        end
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if (beat_cnt1 !== 32'd1 || beat_cnt0 !== 32'd0 || sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_counters: got cnt1=%0d cnt0=%0d pending=%0d, required 1 0 0",
                     beat_cnt1, beat_cnt0, sb.size());
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        lii_out_p0_tready = 1'b1;
        @(negedge aclk);
        force dut.cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0_q;
        checks++;
        if (beat_cnt0 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preset: got %h, required ffffffff", beat_cnt0);
        end
        tick();
        send_s0(56'h77);
        tick();
        @(negedge aclk);
        checks++;
        if (beat_cnt0 !== 32'd0 || beat_cnt1 !== 32'd0) begin
            errors++;
            $display("FAIL wrap_count: got cnt0=%h cnt1=%h, required 0 0", beat_cnt0, beat_cnt1);
        end
        tick();
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        arst              = 1'b1;
        s0_tdata          = '0;
        s0_tvalid         = 1'b0;
        s1_tdata          = '0;
        s1_tvalid         = 1'b0;
        lii_out_p0_tready = 1'b0;

        // Scoreboard: expected beats are queued from the stimulus side at each
        // input handshake and compared at each phy handshake. The phy pop is
        // handled before the push because a beat accepted at the coming edge
        // cannot leave before the edge after it.
        fork
            forever begin
                @(negedge aclk);
                if (arst) begin
                    sb.delete();
                end else begin
                    if (lii_out_p0_tvalid && lii_out_p0_tready) begin
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL sb_extra_beat: got tdata=%h dst=%h, required no beat",
                                     lii_out_p0_tdata, lii_out_p0_dst);
                        end else begin
                            mon_e = sb.pop_front();
                            if (lii_out_p0_tdata !== mon_e.data || lii_out_p0_dst !== mon_e.dst ||
                                lii_out_p0_src !== 8'h00) begin
                                errors++;
                                $display("FAIL sb_beat: got tdata=%h dst=%h src=%h, required %h %h 00",
                                         lii_out_p0_tdata, lii_out_p0_dst, lii_out_p0_src,
                                         mon_e.data, mon_e.dst);
                            end
                        end
                    end
                    if (s0_tvalid && s0_tready) sb.push_back({8'h01, 72'h0, s0_tdata});
                    if (s1_tvalid && s1_tready) sb.push_back({8'h02, 56'h0, s1_tdata});
                end
            end
        join_none

        tick();
        test_reset();
        test_single();
        test_alternate();
        test_backpressure();
        test_full_pushpop();
        test_reset_mid();
        test_wrap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
